// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, NOP word,
// default reset vector and word-alignment helper.
package if_fetch_unit_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, fetched word presented 1 cycle after ack.
// Stalls by holding the presented word while if_id_wr=0; redirects kill in-flight data.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_id_wr,
    output logic        fetch_valid,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_target;
    logic         r_kill;
    logic         r_req;
    logic         r_fv;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc4;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redir_pc;

    // Single adder serves both the sequential advance and the presented pc+4.
    assign w_pc_plus4 = r_pc + INSTR_BYTES;
    assign w_redir_pc = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_target <= RESET_PC;
            r_kill   <= 1'b0;
            r_req    <= 1'b0;
            r_fv     <= 1'b0;
            r_instr  <= NOP;
            r_pc4    <= 32'h0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!r_req) begin
                        // First cycle out of reset: no request on the bus yet, so acks are ignored.
                        r_req <= 1'b1;
                        if (redirect_valid) begin
                            r_pc <= w_redir_pc;
                        end
                    end else if (imem_ack) begin
                        if (redirect_valid) begin
                            r_pc   <= w_redir_pc;
                            r_kill <= 1'b0;
                        end else if (r_kill) begin
                            r_pc   <= r_target;
                            r_kill <= 1'b0;
                        end else begin
                            r_instr <= imem_rdata;
                            r_pc4   <= w_pc_plus4;
                            r_fv    <= 1'b1;
                            r_req   <= 1'b0;
                            r_state <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // The memory request cannot be withdrawn; remember where to go once it completes.
                        r_target <= w_redir_pc;
                        r_kill   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || if_id_wr) begin
                        r_pc    <= redirect_valid ? w_redir_pc : w_pc_plus4;
                        r_fv    <= 1'b0;
                        r_instr <= NOP;
                        r_pc4   <= 32'h0;
                        r_req   <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign fetch_valid  = r_fv;
    assign instr_out    = r_instr;
    assign pc_plus4_out = r_pc4;

    a_req_held : assert property (@(posedge clk) disable iff (rst)
        (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

    a_fv_not_fetch : assert property (@(posedge clk) disable iff (rst)
        fetch_valid |-> (!imem_req && r_state == ST_HOLD));

    a_addr_aligned : assert property (@(posedge clk) disable iff (rst)
        imem_addr[1:0] == 2'b00);

    a_nop_when_idle : assert property (@(posedge clk) disable iff (rst)
        !fetch_valid |-> (instr_out == NOP && pc_plus4_out == 32'h0));

endmodule
